// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with synchronous clear/load, a combinational
// terminal count for cascading, and one-cycle wrap / bad-load pulses.
module updown_mod_counter #(
    parameter int              WIDTH  = 4,   // 2..32
    parameter longint unsigned MODULO = 16   // 2..2**WIDTH
) (
    input  logic             clk,
    input  logic             rst,        // async, active low
    input  logic             en,
    input  logic             up_dn,      // 1 = up, 0 = down
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    // Modulus held one bit wider so MODULO == 2**WIDTH is representable;
    // in that case no load value can be out of range.
    localparam logic [WIDTH:0]   MODV = (WIDTH+1)'(MODULO);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULO - 64'd1);

    logic             at_max;
    logic             at_zero;
    logic             load_oob;
    logic [WIDTH-1:0] cnt_d;
    logic             wrap_d;
    logic             lerr_d;

    assign at_max   = (counter == MAXV);
    assign at_zero  = (counter == '0);
    assign load_oob = ({1'b0, load_val} >= MODV);

    // Terminal count is left unregistered so it can enable the next digit
    // on the very same edge.
    assign tc = en & ((up_dn & at_max) | (~up_dn & at_zero));

    // Next-state: clear beats load beats count beats hold; pulses default low.
    always_comb begin
        cnt_d  = counter;
        wrap_d = 1'b0;
        lerr_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            if (load_oob) begin
                cnt_d  = MAXV;   // saturate so the count never leaves range
                lerr_d = 1'b1;
            end else begin
                cnt_d = load_val;
            end
        end else if (en) begin
            if (up_dn) begin
                if (at_max) begin
                    cnt_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = counter + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    cnt_d  = MAXV;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = counter - WIDTH'(1);
                end
            end
        end
    end

    // State register; reset clears count and any pulse in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter  <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            counter  <= cnt_d;
            wrap     <= wrap_d;
            load_err <= lerr_d;
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter (WIDTH=4, MODULO=10): arithmetic reference
// model checked every cycle, directed scenarios with literal expectations,
// and a two-digit cascade.
module tb_updown_mod_counter;
    localparam int W = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0, up_dn = 1'b1, clr = 1'b0, load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] counter;
    logic         tc, wrap, load_err;

    logic         c_en = 1'b0;
    logic [W-1:0] lo_cnt, hi_cnt;
    logic         lo_tc, hi_tc, lo_wrap, hi_wrap, lo_lerr, hi_lerr;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(W), .MODULO(M)) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .counter(counter), .tc(tc), .wrap(wrap),
        .load_err(load_err));

    updown_mod_counter #(.WIDTH(W), .MODULO(M)) u_lo (
        .clk(clk), .rst(rst), .en(c_en), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
        .load_val(4'd0), .counter(lo_cnt), .tc(lo_tc), .wrap(lo_wrap),
        .load_err(lo_lerr));

    updown_mod_counter #(.WIDTH(W), .MODULO(M)) u_hi (
        .clk(clk), .rst(rst), .en(lo_tc), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
        .load_val(4'd0), .counter(hi_cnt), .tc(hi_tc), .wrap(hi_wrap),
        .load_err(hi_lerr));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: count as an integer modulo M.
    int m_cnt = 0, m_wrap = 0, m_lerr = 0;
    int c_val = 0, c_lo_wrap = 0, c_hi_wrap = 0;
    bit c_chk = 1'b0;
    int hi_pulses = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt = 0; m_wrap = 0; m_lerr = 0;
            c_val = 0; c_lo_wrap = 0; c_hi_wrap = 0;
        end else begin
            m_wrap = 0;
            m_lerr = 0;
            if (clr) m_cnt = 0;
            else if (load) begin
                if (int'(load_val) >= M) begin m_cnt = M - 1; m_lerr = 1; end
                else m_cnt = int'(load_val);
            end else if (en) begin
                if (up_dn) begin m_wrap = (m_cnt == M - 1); m_cnt = (m_cnt + 1) % M; end
                else       begin m_wrap = (m_cnt == 0);     m_cnt = (m_cnt + M - 1) % M; end
            end
            c_lo_wrap = 0;
            c_hi_wrap = 0;
            if (c_en) begin
                c_lo_wrap = (c_val % 10 == 9);
                c_hi_wrap = (c_val == 99);
                c_val = (c_val + 1) % 100;
            end
        end
    end

    // Per-cycle compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("counter", 32'(counter), 32'(m_cnt));
            chk("tc", 32'(tc), 32'((en && ((up_dn && m_cnt == M - 1) || (!up_dn && m_cnt == 0))) ? 1 : 0));
            chk("wrap", 32'(wrap), 32'(m_wrap));
            chk("load_err", 32'(load_err), 32'(m_lerr));
            chk("in_range", 32'(counter < M), 32'd1);
            if (c_chk) begin
                chk("casc_lo", 32'(lo_cnt), 32'(c_val % 10));
                chk("casc_hi", 32'(hi_cnt), 32'(c_val / 10));
                chk("casc_lo_wrap", 32'(lo_wrap), 32'(c_lo_wrap));
                chk("casc_hi_wrap", 32'(hi_wrap), 32'(c_hi_wrap));
                chk("casc_range", 32'(lo_cnt <= 9 && hi_cnt <= 9), 32'd1);
                if (hi_wrap) hi_pulses++;
            end
        end
    end

    // One clock edge; inputs change 2 time units after it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int up_exp[12];
        up_exp = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

        // Reset state, and inputs ignored while reset is held.
        en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 4'd12;
        #3;
        chk("rst_counter", 32'(counter), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_lerr", 32'(load_err), 32'd0);
        tick(); tick();
        chk("rst_hold_counter", 32'(counter), 32'd0);
        chk("rst_hold_lerr", 32'(load_err), 32'd0);
        load = 1'b0; load_val = '0;

        // Up-count 12 edges.
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("up_seq", 32'(counter), 32'(up_exp[i]));
            if (i == 8) chk("up_tc_at9", 32'(tc), 32'd1);
            if (i == 9) chk("up_wrap", 32'(wrap), 32'd1);
            if (i == 10) chk("up_wrap_gone", 32'(wrap), 32'd0);
        end

        // Down-count from 0.
        en = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
        en = 1'b1; up_dn = 1'b0;
        #1 chk("dn_tc_at0", 32'(tc), 32'd1);
        tick(); chk("dn_9", 32'(counter), 32'd9); chk("dn_wrap", 32'(wrap), 32'd1);
        chk("dn_tc_at9", 32'(tc), 32'd0);
        tick(); chk("dn_8", 32'(counter), 32'd8); chk("dn_wrap_gone", 32'(wrap), 32'd0);
        tick(); chk("dn_7", 32'(counter), 32'd7);

        // Priority: clear over load over count.
        en = 1'b0; load = 1'b1; load_val = 4'd5; tick();
        chk("load5", 32'(counter), 32'd5);
        clr = 1'b1; load_val = 4'd3; en = 1'b1; up_dn = 1'b1; tick();
        chk("prio_counter", 32'(counter), 32'd0);
        chk("prio_lerr", 32'(load_err), 32'd0);
        chk("prio_wrap", 32'(wrap), 32'd0);
        clr = 1'b0; en = 1'b0;

        // Bad loads and boundary loads.
        load_val = 4'd12; tick();
        chk("bad_counter", 32'(counter), 32'd9);
        chk("bad_lerr", 32'(load_err), 32'd1);
        load_val = 4'd4; tick();
        chk("good_counter", 32'(counter), 32'd4);
        chk("good_lerr", 32'(load_err), 32'd0);
        load_val = 4'd10; tick();
        chk("edge10_counter", 32'(counter), 32'd9);
        chk("edge10_lerr", 32'(load_err), 32'd1);
        load_val = 4'd9; tick();
        chk("edge9_lerr", 32'(load_err), 32'd0);
        load_val = 4'd15; tick();
        chk("max15_counter", 32'(counter), 32'd9);
        load = 1'b0; tick();
        chk("hold_lerr_clear", 32'(load_err), 32'd0);
        chk("hold_counter", 32'(counter), 32'd9);

        // Direction change takes effect on the same edge; load never wraps.
        en = 1'b1; up_dn = 1'b1; tick();
        chk("up_from9", 32'(counter), 32'd0);
        up_dn = 1'b0; tick();
        chk("dir_change", 32'(counter), 32'd9);
        up_dn = 1'b1; tick(); tick();
        chk("dir_back", 32'(counter), 32'd1);
        en = 1'b0; load = 1'b1; load_val = 4'd0; tick();
        chk("load_no_wrap", 32'(wrap), 32'd0);

        // Async reset mid-count, with en held high.
        load_val = 4'd7; tick(); load = 1'b0;
        chk("pre_rst_7", 32'(counter), 32'd7);
        en = 1'b1; up_dn = 1'b1;
        #3 rst = 1'b0;
        #1 chk("async_counter", 32'(counter), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_first", 32'(counter), 32'd1);

        // Reset in the middle of a load_err pulse leaves nothing behind.
        en = 1'b0; load = 1'b1; load_val = 4'd13; tick(); load = 1'b0;
        chk("pulse_pre", 32'(load_err), 32'd1);
        rst = 1'b0;
        #1 chk("pulse_abort", 32'(load_err), 32'd0);
        tick(); rst = 1'b1; tick();
        chk("pulse_after", 32'(load_err), 32'd0);
        chk("pulse_after_cnt", 32'(counter), 32'd0);

        // Two-digit cascade: 100 edges returns the pair to 00.
        c_chk = 1'b1; c_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i == 0)  chk("casc_01", 32'(hi_cnt * 10 + lo_cnt), 32'd1);
            if (i == 9)  chk("casc_10", 32'(hi_cnt * 10 + lo_cnt), 32'd10);
            if (i == 98) chk("casc_99", 32'(hi_cnt * 10 + lo_cnt), 32'd99);
        end
        c_en = 1'b0;
        chk("casc_final", 32'(hi_cnt * 10 + lo_cnt), 32'd0);
        tick();
        chk("casc_hi_pulses", 32'(hi_pulses), 32'd1);
        c_chk = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits; legal range 2..32.
REQ-002 Parameter MODULO, default 16, count modulus; legal range 2..2^WIDTH; count sequence is 0..MODULO-1.
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-005 en  input  1  count enable; count advances one step per clk edge while 1.
REQ-006 up_dn  input  1  direction; 1 = increment, 0 = decrement.
REQ-007 clr  input  1  synchronous clear to 0.
REQ-008 load  input  1  synchronous parallel load.
REQ-009 load_val  input  WIDTH  parallel load value.
REQ-010 counter  output  WIDTH  registered count value.
REQ-011 tc  output  1  combinational terminal count for cascading: en & ((up_dn & counter==MODULO-1) | (~up_dn & counter==0)).
REQ-012 wrap  output  1  registered one-cycle pulse, 1 in the cycle after a wrap.
REQ-013 load_err  output  1  registered one-cycle pulse, 1 in the cycle after an out-of-range load.

Function
REQ-014 Per-edge priority SHALL be: clr, then load, then en, then hold.
REQ-015 clr=1 -> counter becomes 0; wrap and load_err become 0; load, en, up_dn ignored.
REQ-016 load=1, clr=0, load_val<MODULO -> counter becomes load_val; load_err becomes 0.
REQ-017 load=1, clr=0, load_val>=MODULO -> counter becomes MODULO-1; load_err becomes 1 for exactly one cycle.
REQ-018 en=1, up_dn=1, counter<MODULO-1 -> counter+1; counter==MODULO-1 -> 0 with wrap=1 next cycle.
REQ-019 en=1, up_dn=0, counter>0 -> counter-1; counter==0 -> MODULO-1 with wrap=1 next cycle.
REQ-020 en=0, clr=0, load=0 -> counter holds; wrap and load_err become 0.
REQ-021 Counting latency: counter reflects each step one clk edge after en is sampled high.
REQ-022 wrap SHALL be 1 only in the cycle following an en-driven wrap and never due to clr or load.
REQ-023 tc SHALL be purely combinational, with no register in its path, so the tc of stage N can drive en of stage N+1 with the same clk, giving a synchronous multi-digit chain.
REQ-024 A direction change on any edge SHALL take effect on that edge with no pipeline delay or extra step.
REQ-025 When MODULO==2^WIDTH, wrap SHALL be natural binary roll-over and REQ-017 can never trigger.
REQ-026 counter SHALL never hold a value >= MODULO under any input sequence.

Reset
REQ-027 rst=0 SHALL immediately force counter=0, wrap=0 and load_err=0, independent of clk.
REQ-028 While rst=0, all synchronous inputs SHALL be ignored.
REQ-029 After rst deasserts, the first rising clk edge SHALL act normally per REQ-014.
REQ-030 rst asserted mid-count or mid-pulse SHALL abort the operation with no residual wrap or load_err after release.

Verification
Scenarios use WIDTH=4, MODULO=10.
REQ-031 Up-count: rst release, en=1, up_dn=1 for 12 edges -> counter 1..9,0,1,2; tc=1 while counter==9; wrap=1 one cycle after 9->0.
REQ-032 Down-count: from 0, en=1, up_dn=0 for 3 edges -> counter 9,8,7; wrap=1 one cycle after 0->9; tc=1 at counter==0 only.
REQ-033 Priority: counter=5, clr=1, load=1, load_val=3, en=1 on the same edge -> counter=0; load_err=0; wrap=0.
REQ-034 Bad load: load=1, load_val=12 -> counter=9; load_err=1 for exactly one cycle. Then load_val=4 -> counter=4; load_err=0.
REQ-035 Async reset: rst pulled low between clk edges at counter=7 -> counter=0 before the next edge. With en=1 throughout, the first edge after release gives counter=1.
REQ-036 Cascade: two instances, tc of the low digit drives en of the high digit, 100 up edges -> pair reads 00; high-digit wrap pulses once; no intermediate value exceeds 9 in either digit.
